// File: rtl/dbus_responder.sv
// Data-bus slave backed by a MEM_WORDS x 32 array. Each transaction completes a fixed LATENCY cycles after it is accepted.
// Optional DBUS_RESPONDER_ALIGN_CHECK_EN: misaligned requests skip the write and return 32'hDEADBEEF.
package dbus_pkg;
  typedef enum logic [1:0] {MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2} msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module dbus_responder
  import dbus_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       misalign
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  msize_t      size_q;
  logic [3:0]  strobe_q;
  logic [31:0] data_q;

  logic [31:0] mem [MEM_WORDS];

  logic             mis_l;
  logic [IDX_W-1:0] idx;
  logic             done;

  assign idx  = addr_q[IDX_W+1:2];
  assign done = (state == S_DONE);

`ifdef DBUS_RESPONDER_ALIGN_CHECK_EN
  assign mis_l = ((size_q == MSIZE2) && addr_q[0]) ||
                 ((size_q == MSIZE4) && (addr_q[1:0] != 2'b00));
`else
  assign mis_l = 1'b0;
`endif

  // High address bits alias; size is carried only for the alignment check.
  logic unused;
  assign unused = ^{addr_q[31:IDX_W+2], addr_q[1:0], size_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      size_q   <= MSIZE1;
      strobe_q <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        S_IDLE: if (dreq.valid) begin
          addr_q   <= dreq.addr;
          size_q   <= dreq.size;
          strobe_q <= dreq.strobe;
          data_q   <= dreq.data;
          cnt      <= 4'(LATENCY);
          state    <= (LATENCY > 0) ? S_WAIT : S_DONE;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The write commits on the edge leaving S_DONE, so the response shows the pre-write word.
  always_ff @(posedge clk) begin
    if (done && !mis_l) begin
      for (int i = 0; i < 4; i++)
        if (strobe_q[i]) mem[idx][8*i +: 8] <= data_q[8*i +: 8];
    end
  end

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = (state == S_IDLE) && dreq.valid;
    dresp.data_ok = done;
    if (done) dresp.data = mis_l ? 32'hDEADBEEF : mem[idx];
  end

  assign misalign = done && mis_l;

  a_no_overlap: assert property (@(posedge clk) disable iff (!resetn)
    !(dresp.addr_ok && dresp.data_ok));
endmodule
